// File: rtl/boot_copier_pkg.sv
// Shared types and constants for the boot copier and its helpers.
package boot_copier_pkg;

  localparam int unsigned ROM_AW = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned TMR_W  = 8;

  localparam logic [ROM_AW-1:0] CSUM_ADDR = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR_REQ,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/boot_ack_timer.sv
// Loadable down-counter that flags expiry when it reaches zero.
module boot_ack_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/boot_copier.sv
// Copies a window of boot ROM words into main memory while holding the CPU in reset.
// Define BOOT_CHECKSUM_EN to verify the running sum against ROM word 0xF before release.
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter int unsigned COPY_LEN    = 8,
  parameter int unsigned SRC_BASE    = 0,
  parameter int unsigned DST_BASE    = 0,
  parameter int unsigned DST_AW      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [DST_AW-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  localparam int unsigned       IDX_W    = 5;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COPY_LEN - 1);
  localparam logic [TMR_W-1:0]  TMO_LOAD = (ACK_TIMEOUT > 0) ? TMR_W'(ACK_TIMEOUT - 1) : TMR_W'(0);

  state_e             state_q, state_d;
  logic               boot_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               csum_q, csum_d;
  logic [WORD_W-1:0]  buf_d, chk_d;
  logic               rom_cs_d, mem_cs_d, busy_d, done_d, err_d, cpu_hold_d;
  logic [ROM_AW-1:0]  rom_addr_d;
  logic [DST_AW-1:0]  mem_addr_d;
  logic               tmr_load_c, tmr_dec_c, tmr_expired_c;

  assign rom_we = 1'b0;

  boot_ack_timer #(.W(TMR_W)) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load_c),
    .load_val  (TMO_LOAD),
    .dec       (tmr_dec_c),
    .expired_c (tmr_expired_c)
  );

  // Next state, datapath updates, and output decode of the state being entered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    buf_d      = mem_wdata;
    chk_d      = checksum;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = RD_REQ;
          idx_d   = '0;
          csum_d  = 1'b0;
          chk_d   = '0;
        end
      end
      RD_REQ: begin
        // first cycle after reset only loads the RD_REQ strobes
        if (!boot_q) state_d = RD_CAP;
      end
      RD_CAP: begin
        if (csum_q) begin
          state_d = (rom_rdata == checksum) ? DONE : ERROR;
        end else begin
          buf_d      = rom_rdata;
          chk_d      = checksum + rom_rdata;
          state_d    = WR_REQ;
          tmr_load_c = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q != LAST_IDX) begin
            state_d = RD_REQ;
          end else begin
`ifdef BOOT_CHECKSUM_EN
            state_d = RD_REQ;
            csum_d  = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end else if (tmr_expired_c) begin
          state_d = ERROR;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rom_cs_d   = (state_d == RD_REQ) || (state_d == RD_CAP);
    rom_addr_d = csum_d ? CSUM_ADDR : ROM_AW'(SRC_BASE) + idx_d[ROM_AW-1:0];
    mem_cs_d   = (state_d == WR_REQ);
    mem_addr_d = DST_AW'(DST_BASE) + DST_AW'(idx_d);
    busy_d     = rom_cs_d || mem_cs_d;
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERROR);
    cpu_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_REQ;
      boot_q    <= 1'b1;
      idx_q     <= '0;
      csum_q    <= 1'b0;
      mem_wdata <= '0;
      checksum  <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state_q   <= state_d;
      boot_q    <= 1'b0;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      mem_wdata <= buf_d;
      checksum  <= chk_d;
      rom_cs    <= rom_cs_d;
      rom_addr  <= rom_addr_d;
      mem_cs    <= mem_cs_d;
      mem_we    <= mem_cs_d;
      mem_addr  <= mem_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cpu_hold  <= cpu_hold_d;
    end
  end

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: default instance plus a wrapping-source instance.
module tb_boot_copier;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int EXTRA = CSUM ? 2 : 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic        rom_cs, rom_we, mem_cs, mem_we, mem_ack;
  logic [3:0]  rom_addr;
  logic [15:0] rom_rdata, mem_wdata, checksum;
  logic [7:0]  mem_addr;
  logic        cpu_hold, busy, done, err;

  logic        w_rom_cs, w_rom_we, w_mem_cs, w_mem_we, w_cpu_hold, w_busy, w_done, w_err;
  logic [3:0]  w_rom_addr;
  logic [15:0] w_rom_rdata, w_mem_wdata, w_checksum;
  logic [7:0]  w_mem_addr;

  logic [15:0] rom [16];
  logic [15:0] mem [256];
  logic        clr_mem = 1'b0;
  int          ack_mode = 0;
  logic [3:0]  wcnt = '0;

  int n_checks = 0;
  int n_fail   = 0;

  boot_copier u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  boot_copier #(.COPY_LEN(4), .SRC_BASE(14), .DST_BASE(8'h40)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(1'b0),
    .rom_cs(w_rom_cs), .rom_we(w_rom_we), .rom_addr(w_rom_addr), .rom_rdata(w_rom_rdata),
    .mem_cs(w_mem_cs), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_ack(1'b1), .cpu_hold(w_cpu_hold), .busy(w_busy), .done(w_done), .err(w_err),
    .checksum(w_checksum)
  );

  // ROM models latch data while selected for read
  always @(posedge clk) begin
    if (rom_cs && !rom_we) rom_rdata <= rom[rom_addr];
    if (w_rom_cs && !w_rom_we) w_rom_rdata <= rom[w_rom_addr];
  end

  // ack modes: 0 tied high, 1 after 3 wait cycles, 2 never on address 2
  always_comb begin
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = mem_cs && (wcnt == 4'd3);
      default: mem_ack = mem_cs && (mem_addr != 8'd2);
    endcase
  end

  always @(posedge clk) begin
    if (mem_cs && !mem_ack) wcnt <= wcnt + 4'd1;
    else wcnt <= '0;
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
    end else if (mem_cs && mem_we && mem_ack) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // negedge monitors: write stability, word-2 wait length, wrap-instance logs
  logic        p_cs = 1'b0;
  logic [7:0]  p_addr;
  logic [15:0] p_data;
  int          unstable = 0;
  int          w2_wait = 0;
  logic        w_cs_p = 1'b0;
  int          w_nrd = 0, w_nwr = 0;
  logic [3:0]  w_rd [8];
  logic [7:0]  w_wa [8];
  logic [15:0] w_wd [8];

  always @(negedge clk) begin
    if (rst_n && mem_cs && p_cs && (mem_addr != p_addr || mem_wdata != p_data)) unstable++;
    p_cs   = mem_cs;
    p_addr = mem_addr;
    p_data = mem_wdata;
    if (ack_mode == 2 && mem_cs && mem_addr == 8'd2) w2_wait++;
    if (w_rom_cs && !w_cs_p && w_nrd < 8) begin
      w_rd[w_nrd] = w_rom_addr;
      w_nrd++;
    end
    w_cs_p = w_rom_cs;
    if (w_mem_cs && w_mem_we && w_nwr < 8) begin
      w_wa[w_nwr] = w_mem_addr;
      w_wd[w_nwr] = w_mem_wdata;
      w_nwr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return rom_cs;
      1:       return done || err;
      2:       return mem_cs;
      default: return mem_cs && (mem_addr == 8'd4);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int budget, output int cyc);
    cyc = 0;
    while (!cond(which) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_reached"}, 32'(cond(which)), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
  endtask

  task automatic check_image(input string tag);
    check({tag, "_m0"}, 32'(mem[0]), 32'h0000_F200);
    check({tag, "_m3"}, 32'(mem[3]), 32'h0000_F400);
    check({tag, "_m4"}, 32'(mem[4]), 32'h0000_B007);
    check({tag, "_m7"}, 32'(mem[7]), 32'h0000_000F);
  endtask

  int cyc;

  initial begin
    rom[0]  = 16'hF200; rom[1]  = 16'h4000; rom[2]  = 16'hF800; rom[3]  = 16'hF400;
    rom[4]  = 16'hB007; rom[5]  = 16'h6007; rom[6]  = 16'h4000; rom[7]  = 16'h000F;
    rom[8]  = 16'h0808; rom[9]  = 16'h0909; rom[10] = 16'h0A0A; rom[11] = 16'h0B0B;
    rom[12] = 16'h0C0C; rom[13] = 16'h0D0D; rom[14] = 16'h1234; rom[15] = 16'h0000;
    rst_n = 1'b0;
    start = 1'b0;
    clr_mem = 1'b1;
    repeat (3) @(negedge clk);
    clr_mem = 1'b0;

    // reset values
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);

    // test 1: automatic copy with ack tied high
    rst_n = 1'b1;
    wait_for("t1_rd", 0, 5, cyc);
    check("t1_first_rom_addr", 32'(rom_addr), 32'd0);
    check("t1_rom_we", 32'(rom_we), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_for("t1_end", 1, 100, cyc);
    check("t1_cycles", 32'(cyc), 32'(24 + EXTRA));
    check("t1_done", 32'(done), 32'(!CSUM));
    check("t1_err", 32'(err), 32'(CSUM));
    check("t1_cpu_hold", 32'(cpu_hold), 32'(CSUM));
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_checksum", 32'(checksum), 32'h0000_6E1D);
    check_image("t1");

    // test 6: wrapping source window on the second instance
    check("t6_rd0", 32'(w_rd[0]), 32'hE);
    check("t6_rd1", 32'(w_rd[1]), 32'hF);
    check("t6_rd2", 32'(w_rd[2]), 32'h0);
    check("t6_rd3", 32'(w_rd[3]), 32'h1);
    check("t6_wa0", 32'(w_wa[0]), 32'h40);
    check("t6_wa3", 32'(w_wa[3]), 32'h43);
    check("t6_wd0", 32'(w_wd[0]), 32'h1234);
    check("t6_wd2", 32'(w_wd[2]), 32'hF200);
    check("t6_checksum", 32'(w_checksum), 32'h4434);

    if (CSUM) rom[15] = 16'h6E1D;

    // test 2: three-cycle ack delay, outputs must hold through each wait
    ack_mode = 1;
    clear_mem();
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    wait_for("t2_rd", 0, 5, cyc);
    wait_for("t2_end", 1, 200, cyc);
    check("t2_cycles", 32'(cyc), 32'(48 + EXTRA));
    check("t2_done", 32'(done), 32'd1);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t2_checksum", 32'(checksum), 32'h0000_6E1D);
    check("t2_stable", 32'(unstable), 32'd0);
    check_image("t2");

    // test 3: no ack on word 2 -> timeout
    ack_mode = 2;
    clear_mem();
    pulse_start();
    wait_for("t3_end", 1, 200, cyc);
    check("t3_err", 32'(err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_mem_cs", 32'(mem_cs), 32'd0);
    check("t3_wait_len", 32'(w2_wait), 32'd15);
    check("t3_checksum", 32'(checksum), 32'h0000_2A00);
    check("t3_m0", 32'(mem[0]), 32'h0000_F200);
    check("t3_m1", 32'(mem[1]), 32'h0000_4000);
    check("t3_m2", 32'(mem[2]), 32'h0000_DEAD);
    repeat (3) @(negedge clk);
    check("t3_err_sticky", 32'(err), 32'd1);

    // restart after error begins again at index 0
    ack_mode = 0;
    clear_mem();
    pulse_start();
    check("t3r_err_cleared", 32'(err), 32'd0);
    wait_for("t3r_rd", 0, 5, cyc);
    check("t3r_rom_addr", 32'(rom_addr), 32'd0);
    wait_for("t3r_wr", 2, 10, cyc);
    check("t3r_mem_addr", 32'(mem_addr), 32'd0);
    wait_for("t3r_end", 1, 100, cyc);
    check("t3r_done", 32'(done), 32'd1);
    check_image("t3r");

    // test 4: reset asserted during the word-4 write
    clear_mem();
    pulse_start();
    wait_for("t4_w4", 3, 60, cyc);
    check("t4_mem_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_mem_we", 32'(mem_we), 32'd0);
    check("t4_mem_cs", 32'(mem_cs), 32'd0);
    check("t4_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_for("t4_rd", 0, 5, cyc);
    check("t4_rom_addr", 32'(rom_addr), 32'd0);
    wait_for("t4_wr", 2, 10, cyc);
    check("t4_mem_addr", 32'(mem_addr), 32'd0);
    check("t4_mem_wdata", 32'(mem_wdata), 32'h0000_F200);
    wait_for("t4_end", 1, 100, cyc);
    check("t4_done", 32'(done), 32'd1);
    check("t4_checksum", 32'(checksum), 32'h0000_6E1D);
    check_image("t4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
Bus initiator that reads the 16-bit boot ROM (4-bit word address, cs/we handshake) after reset and copies a fixed window of words into main memory. It holds the CPU in reset until the copy completes. It sits between the boot ROM slave port and the memory write port, ahead of the CPU in the SoC boot path.

Parameters:
COPY_LEN, 8, number of words copied (1..16), starting at SRC_BASE.
SRC_BASE, 0, first boot ROM word address (4 bits); the source address wraps modulo 16.
DST_BASE, 0, first destination memory word address.
DST_AW, 8, destination address width.
ACK_TIMEOUT, 15, maximum cycles to wait for mem_ack before flagging an error.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; re-runs the copy from IDLE or DONE
rom_cs  out  1  boot ROM chip select
rom_we  out  1  boot ROM write enable; tied 0 (read-only initiator)
rom_addr  out  4  boot ROM word address
rom_rdata  in  16  boot ROM data out (latched while cs & ~we)
mem_cs  out  1  destination memory select
mem_we  out  1  destination write strobe
mem_addr  out  DST_AW  destination word address
mem_wdata  out  16  write data
mem_ack  in  1  write accepted (sampled on the rising edge of clk)
cpu_hold  out  1  holds the CPU in reset while high
busy  out  1  copy in progress
done  out  1  copy finished successfully; sticky until the next start
err  out  1  timeout (or checksum mismatch); sticky until the next start
checksum  out  16  running 16-bit sum of the words copied

Behaviour:
- Reset values: all outputs 0 except cpu_hold=1. FSM enters RD_REQ directly; the copy starts automatically on the first clock after rst_n rises.
- States: IDLE, RD_REQ, RD_CAP, WR_REQ, DONE, ERROR.
- IDLE: cpu_hold=1. A start pulse clears done/err/checksum, clears the index, and goes to RD_REQ.
- RD_REQ (1 cycle): rom_cs=1, rom_we=0, rom_addr=SRC_BASE+idx (4-bit wrap). Next state RD_CAP.
- RD_CAP (1 cycle): rom_cs stays 1 and rom_addr is held. rom_rdata is registered into the data buffer. checksum += data (mod 2^16). Next state WR_REQ.
- WR_REQ:
  - Outputs: rom_cs=0; mem_cs=mem_we=1; mem_addr=DST_BASE+idx (truncated to DST_AW); mem_wdata=buffer.
  - Outputs stay stable until mem_ack.
  - On mem_ack: idx++. If idx==COPY_LEN-1, go to DONE; otherwise go to RD_REQ.
  - A wait counter counts cycles without ack. When it reaches ACK_TIMEOUT, go to ERROR.
- Read-to-read spacing is therefore at least 3 cycles; latency per word is 3 cycles with an immediate ack.
- DONE: done=1, busy=0, cpu_hold=0, all strobes 0.
- ERROR: err=1, busy=0, cpu_hold stays 1, all strobes 0. Only start or reset leaves this state.
- busy=1 in RD_REQ, RD_CAP and WR_REQ.
- A start pulse during busy is ignored.
- A reset asserted mid-copy immediately forces the reset values, including deasserting mem_cs/mem_we. The copy restarts from idx=0 after reset is released.
- mem_ack outside WR_REQ is ignored.

Optional Feature:
BOOT_CHECKSUM_EN.
- Defined: after the last write, one extra read cycle pair (RD_REQ/RD_CAP) fetches ROM word 0xF as the expected sum.
  - Equal to checksum: go to DONE.
  - Not equal: go to ERROR with err=1 and cpu_hold held.
- Undefined: no extra read; checksum is still computed but never compared. Successful completion always goes to DONE.

Decomposition:
- Shared package holds:
  - the state enum;
  - ROM_AW=4 and WORD_W=16;
  - CSUM_ADDR=4'hF.
- One sub-module, boot_ack_timer: loadable down-counter with a timeout flag. It is reused by other bus initiators.

Test Plan:
1. Release reset with ROM at power-up contents and mem_ack tied 1 -> memory 0..7 = F200,4000,F800,F400,B007,6007,4000,000F. done=1 and cpu_hold=0 after 24 cycles; checksum=16'h6E1D.
2. mem_ack delayed 3 cycles on each write -> same data. mem_addr/mem_wdata stay stable through each wait; done after 48 cycles.
3. mem_ack never asserts on word 2 -> err=1 after ACK_TIMEOUT cycles. cpu_hold stays 1; words 0..1 written; a start pulse restarts from idx=0.
4. rst_n pulsed low during word 4 write -> mem_we=0 in the same cycle. On release, the copy restarts at ROM addr 0 and mem_addr=DST_BASE.
5. BOOT_CHECKSUM_EN with ROM word F=0000 -> err=1, cpu_hold=1. With word F written to 6E1D, the run ends with done=1.
6. SRC_BASE=14, COPY_LEN=4 -> ROM addresses read are E,F,0,1 (wrap). Destinations are DST_BASE..+3.
